// File: rtl/mult_div_unit.sv
// Iterative multicycle multiply/divide unit: shift-add multiply, restoring divide, sign fix-up pass.
// Optional mthi/mtlo write ports are enabled by defining MULTDIV_MTHILO_EN.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULTDIV_MTHILO_EN
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] p_hi, p_lo;
    logic             neg_res, neg_rem, is_mult, b_zero;

    logic             accept, a_neg, b_neg, last_iter;
    logic [WIDTH-1:0] a_mag, b_mag, rem_next;
    logic [WIDTH:0]   mult_sum, trial;
    logic [2*WIDTH-1:0] product;

    assign accept    = (state == IDLE) && (start_mult || start_div);
    assign a_neg     = is_signed && a[WIDTH-1];
    assign b_neg     = is_signed && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // p_hi/p_lo double as partial product + multiplier, or partial remainder + dividend/quotient
    assign mult_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
    assign trial    = {p_hi, p_lo[WIDTH-1]} - {1'b0, mcand};
    assign rem_next = trial[WIDTH] ? {p_hi[WIDTH-2:0], p_lo[WIDTH-1]} : trial[WIDTH-1:0];
    assign product  = {p_hi, p_lo};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start_mult)     next_state = MULT;
                else if (start_div) next_state = DIV;
            end
            MULT: begin
                busy = 1'b1;
                if (last_iter) next_state = FIX;
            end
            DIV: begin
                busy = 1'b1;
                if (b_zero)         next_state = DONE;
                else if (last_iter) next_state = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            mcand    <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            is_mult  <= 1'b0;
            b_zero   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_mult  <= start_mult;
                        mcand    <= start_mult ? a_mag : b_mag;
                        p_lo     <= start_mult ? b_mag : a_mag;
                        p_hi     <= '0;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        cnt      <= '0;
                        b_zero   <= (b == '0);
                        div_zero <= !start_mult && (b == '0);
                    end
`ifdef MULTDIV_MTHILO_EN
                    else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
`endif
                end
                MULT: begin
                    {p_hi, p_lo} <= {mult_sum, p_lo[WIDTH-1:1]};
                    cnt          <= cnt + CW'(1);
                end
                DIV: begin
                    if (!b_zero) begin
                        p_hi <= rem_next;
                        p_lo <= {p_lo[WIDTH-2:0], ~trial[WIDTH]};
                        cnt  <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    // remainder follows the dividend's sign, quotient/product the sign product
                    if (is_mult) begin
                        {hi, lo} <= neg_res ? -product : product;
                    end else begin
                        lo <= neg_res ? -p_lo : p_lo;
                        hi <= neg_rem ? -p_hi : p_hi;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multicycle multiply/divide unit for the MIPS datapath. Executes mult/multu and div/divu.
- Takes operands from the A and B register outputs. Produces the HI and LO values that feed the RegData mux (mfhi/mflo paths).
- Reports busy/done to Unidade_Controle, which holds in a wait state until done.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_mult  input  1  one-cycle request: multiply a by b.
- start_div  input  1  one-cycle request: divide a by b.
- is_signed  input  1  1 = mult/div (two's complement); 0 = multu/divu. Sampled with start.
- a  input  WIDTH  multiplicand / dividend (RegA_out).
- b  input  WIDTH  multiplier / divisor (RegB_out).
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  last div had b==0. Sticky until next accepted start.

Behaviour:
- Reset (reset==0, asynchronous):
  - hi, lo, busy, done, div_zero all 0.
  - State goes to IDLE; iteration counter cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - Start is accepted on the rising edge where start_mult or start_div is 1.
  - a, b and is_signed are latched at that edge, and div_zero is cleared.
  - If both starts are high, multiply wins.
  - Starts seen in any state other than IDLE are ignored.
- Operands:
  - If signed, magnitudes |a| and |b| are latched, plus sign flags.
  - Unsigned operands are used as-is.
- MULT:
  - Shift-add, one multiplier bit per cycle.
  - Exactly WIDTH iteration cycles, counter 0..WIDTH-1, then FIX.
- DIV:
  - Restoring division on the magnitudes, one quotient bit per cycle, WIDTH cycles, then FIX.
  - If b==0 at acceptance, DIV is skipped:
    - go directly to DONE;
    - div_zero=1;
    - hi and lo are unchanged.
- FIX (1 cycle):
  - Signed mult: 2WIDTH-bit product negated if the operand signs differ.
  - Signed div: quotient negated if the signs differ; remainder takes the dividend's sign.
  - hi and lo are written at the end of FIX.
- DONE (1 cycle): done=1, then return to IDLE.
- busy is 1 in MULT, DIV and FIX, and 0 in IDLE and DONE.
- Latency: start accepted at edge N gives done high during the cycle after edge N+WIDTH+1, i.e. 34 cycles for WIDTH=32. A divide by zero gives done after edge N+1.
- hi and lo hold their value from end of FIX until the next operation's FIX. They are never disturbed mid-operation.
- Overflow cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no flag).
  - Multiply never overflows (full 64-bit result).
- A new start may be accepted in the IDLE cycle immediately after DONE.

Optional Feature:
- Macro: MULTDIV_MTHILO_EN.
- When defined, adds three ports:
  - wr_hi  input  1
  - wr_lo  input  1
  - wr_data  input  WIDTH
- In IDLE, wr_hi and wr_lo load wr_data into hi and lo on the clock edge (mthi/mtlo). Both may be asserted in the same cycle.
- A start in the same cycle as a write takes precedence; the write is dropped.
- Writes while busy are ignored.
- When the macro is undefined, these ports do not exist and hi/lo change only via FIX.

Test Plan:
- Signed multiply: start_mult, is_signed=1, a=7, b=0xFFFFFFFD → done 34 cycles later; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- Unsigned multiply: is_signed=0, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Unsigned divide: start_div, a=100, b=7 → lo=14, hi=2, div_zero=0. Signed divide: a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: hi/lo preloaded 0x1234/0x5678, start_div, b=0 → done 2 cycles after start; div_zero=1; hi/lo unchanged; next start clears div_zero.
- Reset mid-op: assert reset 10 cycles into a multiply → hi=lo=0, busy=0, no done pulse. After release, a new op completes normally. A start_mult pulsed while busy is ignored.
- With MULTDIV_MTHILO_EN: wr_hi=1, wr_data=0xCAFEBABE in IDLE → hi=0xCAFEBABE next cycle. wr_lo together with start_mult → write dropped, multiply proceeds.
